mcpu_mem_pt_walk_pdc: RTL

Two-level page-table walker with a parametrised, fully-associative page-directory-entry cache (PDC). It sits between the TLB and the L2-cache arbiter. On a TLB miss it fetches the page-directory entry (PDE) and then the page-table entry (PTE) as 256-bit atoms, and returns the translation. A PDC hit skips the PDE read, so the walk is a single memory access.

---
 rtl/mcpu_mem_pt_walk_pdc.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mcpu_mem_pt_walk_pdc.sv
`default_nettype none
// ============================================================================
// Module      : mcpu_mem_pt_walk_pdc
// Description : Two-level page-table walker between the TLB and the L2-cache
//               arbiter. Reads the PDE and then the PTE as 256-bit atoms and
//               returns the translation. An optional fully-associative
//               page-directory-entry cache (PDC) lets a hit skip the PDE read.
//               Build option: define MCPU_MEM_PTW_PDC_EN to include the PDC;
//               without it every walk performs both reads.
// Revision    : 1.0 - initial release
// ============================================================================
module mcpu_mem_pt_walk_pdc #(
  parameter int PDC_ENTRIES = 4
) (
  input  logic          tlb2ptw_clk,
  input  logic          tlb2ptw_rst_n,
  input  logic [31:12]  tlb2ptw_addr,
  input  logic          tlb2ptw_re,
  input  logic [19:0]   ptw_pagedir_base,
  input  logic          ptw_pdc_inval,
  output logic          tlb2ptw_ready,
  output logic          tlb2ptw_done,
  output logic [31:12]  tlb2ptw_phys_addr,
  output logic [3:0]    tlb2ptw_pagetab_flags,
  output logic [3:0]    tlb2ptw_pagedir_flags,
  output logic          ptw2arb_valid,
  output logic [2:0]    ptw2arb_opcode,
  output logic [31:5]   ptw2arb_addr,
  input  logic [255:0]  ptw2arb_rdata,
  input  logic          ptw2arb_rvalid,
  input  logic          ptw2arb_stall
);

  localparam logic [2:0] c_ltc_opc_read = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PD_REQ  = 3'd1,
    S_PD_WAIT = 3'd2,
    S_PT_REQ  = 3'd3,
    S_PT_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:12]  r_vaddr;      // latched virtual page of the walk in flight
  logic [19:0]   r_base;       // latched page-directory base (PDC tag source)
  logic [31:0]   r_pde;
  logic [31:0]   r_pte;
  logic          w_lookup_hit;
  logic [31:0]   w_lookup_pde;
  logic          w_fill;
  logic [31:0]   w_rd_pd_word;
  logic [31:0]   w_rd_pt_word;

  // Select the 32-bit word inside the returned atom: dir_offs[2:0] / pt_offs[2:0]
  assign w_rd_pd_word = ptw2arb_rdata[{r_vaddr[24:22], 5'b00000} +: 32];
  assign w_rd_pt_word = ptw2arb_rdata[{r_vaddr[14:12], 5'b00000} +: 32];

  // Only present PDEs returned in PD_WAIT are candidates for the cache
  assign w_fill = (r_state == S_PD_WAIT) && ptw2arb_rvalid && w_rd_pd_word[0];

  assign ptw2arb_opcode        = c_ltc_opc_read;
  assign tlb2ptw_phys_addr     = r_pte[31:12];
  assign tlb2ptw_pagetab_flags = r_pte[3:0];
  assign tlb2ptw_pagedir_flags = r_pde[3:0];

  // Walk state register; reset aborts any walk in progress
  always_ff @(posedge tlb2ptw_clk or negedge tlb2ptw_rst_n) begin
    if (!tlb2ptw_rst_n) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // Next-state decode and status outputs
  always_comb begin
    w_state_nxt   = r_state;
    tlb2ptw_ready = 1'b0;
    tlb2ptw_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        tlb2ptw_ready = 1'b1;
        if (tlb2ptw_re) w_state_nxt = w_lookup_hit ? S_PT_REQ : S_PD_REQ;
      end
      S_PD_REQ:  if (!ptw2arb_stall) w_state_nxt = S_PD_WAIT;
      S_PD_WAIT: if (ptw2arb_rvalid) w_state_nxt = w_rd_pd_word[0] ? S_PT_REQ : S_DONE;
      S_PT_REQ:  if (!ptw2arb_stall) w_state_nxt = S_PT_WAIT;
      S_PT_WAIT: if (ptw2arb_rvalid) w_state_nxt = S_DONE;
      S_DONE: begin
        tlb2ptw_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Request register and walk datapath (latched address, PDE, PTE)
  always_ff @(posedge tlb2ptw_clk or negedge tlb2ptw_rst_n) begin
    if (!tlb2ptw_rst_n) begin
      ptw2arb_valid <= 1'b0;
      ptw2arb_addr  <= '0;
      r_vaddr       <= '0;
      r_base        <= '0;
      r_pde         <= '0;
      r_pte         <= '0;
    end else begin
      // valid tracks the REQ states exactly, registered from the next state
      ptw2arb_valid <= (w_state_nxt == S_PD_REQ) || (w_state_nxt == S_PT_REQ);
      case (r_state)
        S_IDLE: begin
          if (tlb2ptw_re) begin
            r_vaddr <= tlb2ptw_addr;
            r_base  <= ptw_pagedir_base;
            if (w_lookup_hit) begin
              r_pde        <= w_lookup_pde;
              ptw2arb_addr <= {w_lookup_pde[31:12], tlb2ptw_addr[21:15]};
            end else begin
              ptw2arb_addr <= {ptw_pagedir_base, tlb2ptw_addr[31:25]};
            end
          end
        end
        S_PD_WAIT: begin
          if (ptw2arb_rvalid) begin
            r_pde <= w_rd_pd_word;
            if (w_rd_pd_word[0]) ptw2arb_addr <= {w_rd_pd_word[31:12], r_vaddr[21:15]};
            else                 r_pte        <= '0;
          end
        end
        S_PT_WAIT: begin
          if (ptw2arb_rvalid) r_pte <= w_rd_pt_word;
        end
        default: ;
      endcase
    end
  end

`ifdef MCPU_MEM_PTW_PDC_EN
  localparam int IDX_W = (PDC_ENTRIES > 1) ? $clog2(PDC_ENTRIES) : 1;

  logic [PDC_ENTRIES-1:0] r_pdc_vld;
  logic [29:0]            r_pdc_tag [PDC_ENTRIES];
  logic [31:0]            r_pdc_pde [PDC_ENTRIES];
  logic [IDX_W-1:0]       r_rr;
  logic [IDX_W-1:0]       w_victim;
  logic [29:0]            w_lookup_tag;
  logic [29:0]            w_fill_tag;

  // Tag is {pagedir_base, dir_offs}; lookup uses live inputs, fill uses latched ones
  assign w_lookup_tag = {ptw_pagedir_base, tlb2ptw_addr[31:22]};
  assign w_fill_tag   = {r_base, r_vaddr[31:22]};

  // Associative lookup; at most one entry can match, so OR-merging is safe
  always_comb begin
    w_lookup_hit = 1'b0;
    w_lookup_pde = '0;
    for (int i = 0; i < PDC_ENTRIES; i++) begin
      if (r_pdc_vld[i] && (r_pdc_tag[i] == w_lookup_tag)) begin
        w_lookup_hit = 1'b1;
        w_lookup_pde = w_lookup_pde | r_pdc_pde[i];
      end
    end
  end

  // Victim: lowest-numbered invalid entry, else the round-robin pointer
  always_comb begin
    w_victim = r_rr;
    for (int i = PDC_ENTRIES - 1; i >= 0; i--) begin
      if (!r_pdc_vld[i]) w_victim = IDX_W'(i);
    end
  end

  // Entry payload; validity is tracked separately so no reset is needed here
  always_ff @(posedge tlb2ptw_clk) begin
    if (w_fill && !ptw_pdc_inval) begin
      r_pdc_tag[w_victim] <= w_fill_tag;
      r_pdc_pde[w_victim] <= w_rd_pd_word;
    end
  end

  // Valid bits and replacement pointer; invalidate overrides a same-cycle fill
  always_ff @(posedge tlb2ptw_clk or negedge tlb2ptw_rst_n) begin
    if (!tlb2ptw_rst_n) begin
      r_pdc_vld <= '0;
      r_rr      <= '0;
    end else if (ptw_pdc_inval) begin
      r_pdc_vld <= '0;
    end else if (w_fill) begin
      r_pdc_vld[w_victim] <= 1'b1;
      r_rr <= (r_rr == IDX_W'(PDC_ENTRIES - 1)) ? '0 : r_rr + IDX_W'(1);
    end
  end
`else
  // No cache: every lookup misses, so each walk reads the PDE first
  assign w_lookup_hit = 1'b0;
  assign w_lookup_pde = '0;

  logic w_unused_pdc;
  assign w_unused_pdc = ^{ptw_pdc_inval, r_base, r_vaddr, w_fill, (PDC_ENTRIES != 0)};
`endif

  // Flag-to-address gap bits of the entries are carried but never consumed
  logic w_unused;
  assign w_unused = ^{r_pde[11:4], r_pte[11:4]};

endmodule
`default_nettype wire
